// File: rtl/alu_stage_if.sv
// Issue / CDB bus between the reservation station, commit logic and the ALU stage.
// The master modport is the environment side; the slave modport is the ALU itself.
interface alu_stage_if;
    logic        _clear;
    logic        _alu_ready;
    logic [4:0]  _alu_type;
    logic [4:0]  _alu_rob_id;
    logic [31:0] _alu_r1;
    logic [31:0] _alu_r2;
    logic        _alu_full;
    logic        _cdb_grant;
    logic        _cdb_ready;
    logic [4:0]  _cdb_rob_id;
    logic [31:0] _cdb_value;

    modport master (
        output _clear, _alu_ready, _alu_type, _alu_rob_id, _alu_r1, _alu_r2, _cdb_grant,
        input  _alu_full, _cdb_ready, _cdb_rob_id, _cdb_value
    );

    modport slave (
        input  _clear, _alu_ready, _alu_type, _alu_rob_id, _alu_r1, _alu_r2, _cdb_grant,
        output _alu_full, _cdb_ready, _cdb_rob_id, _cdb_value
    );
endinterface

// File: rtl/alu_stage.sv
// ALU stage: issue register S feeding a 2-entry result FIFO whose head drives the CDB.
// Optional build macro ALU_STAGE_BYPASS_EN removes S and computes straight from the
// issue bus into the FIFO on the accept edge (1-edge latency instead of 2).
module alu_stage (
    input  logic      clk_in,
    input  logic      rst_in,
    input  logic      rdy_in,
    alu_stage_if.slave bus
);

    function automatic logic [31:0] alu_calc(input logic [4:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        logic [31:0] r;
        r = '0;
        case (op)
            5'd0:    r = a + b;
            5'd1:    r = a - b;
            5'd2:    r = a & b;
            5'd3:    r = a | b;
            5'd4:    r = a ^ b;
            5'd5:    r = a << b[4:0];
            5'd6:    r = a >> b[4:0];
            5'd7:    r = 32'($signed(a) >>> b[4:0]);
            5'd8:    r = {31'd0, $signed(a) < $signed(b)};
            5'd9:    r = {31'd0, a < b};
            5'd10:   r = {31'd0, a == b};
            5'd11:   r = {31'd0, a != b};
            5'd12:   r = {31'd0, $signed(a) < $signed(b)};
            5'd13:   r = {31'd0, $signed(a) >= $signed(b)};
            5'd14:   r = {31'd0, a < b};
            5'd15:   r = {31'd0, a >= b};
            default: r = '0;
        endcase
        return r;
    endfunction

    // FIFO state
    logic [1:0]  cnt_q, cnt_d;
    logic        rd_q, rd_d, wr_q, wr_d;
    logic [4:0]  fifo_tag_q [2];
    logic [31:0] fifo_val_q [2];

    logic clr, pop, accept, push;
    logic [4:0]  op_sel, tag_sel;
    logic [31:0] a_sel, b_sel, result;

    // Clear only acts while the stage is enabled; it overrides accept, push and pop.
    assign clr    = rdy_in & bus._clear;
    assign pop    = rdy_in & ~bus._clear & (cnt_q != 2'd0) & bus._cdb_grant;
    assign accept = rdy_in & ~bus._clear & bus._alu_ready & ~bus._alu_full;

`ifdef ALU_STAGE_BYPASS_EN
    assign push    = accept;
    assign op_sel  = bus._alu_type;
    assign tag_sel = bus._alu_rob_id;
    assign a_sel   = bus._alu_r1;
    assign b_sel   = bus._alu_r2;
    assign bus._alu_full = (cnt_q == 2'd2);
`else
    logic        s_vld_q, s_vld_d;
    logic [4:0]  s_type_q, s_type_d, s_tag_q, s_tag_d;
    logic [31:0] s_r1_q, s_r1_d, s_r2_q, s_r2_d;

    // S drains into the FIFO whenever a slot is free, counting the same-edge pop.
    assign push    = rdy_in & ~bus._clear & s_vld_q & ((cnt_q != 2'd2) | pop);
    assign op_sel  = s_type_q;
    assign tag_sel = s_tag_q;
    assign a_sel   = s_r1_q;
    assign b_sel   = s_r2_q;
    // Conservative: a pending pop is not credited, so full never depends on grant.
    assign bus._alu_full = (cnt_q == 2'd2) | ((cnt_q == 2'd1) & s_vld_q);

    // S next-state: clear wins, then a new accept, then drain on push.
    always_comb begin
        s_vld_d  = s_vld_q;
        s_type_d = s_type_q;
        s_tag_d  = s_tag_q;
        s_r1_d   = s_r1_q;
        s_r2_d   = s_r2_q;
        if (clr) begin
            s_vld_d = 1'b0;
        end else if (accept) begin
            s_vld_d  = 1'b1;
            s_type_d = bus._alu_type;
            s_tag_d  = bus._alu_rob_id;
            s_r1_d   = bus._alu_r1;
            s_r2_d   = bus._alu_r2;
        end else if (push) begin
            s_vld_d = 1'b0;
        end
    end

    // S register
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            s_vld_q  <= 1'b0;
            s_type_q <= '0;
            s_tag_q  <= '0;
            s_r1_q   <= '0;
            s_r2_q   <= '0;
        end else begin
            s_vld_q  <= s_vld_d;
            s_type_q <= s_type_d;
            s_tag_q  <= s_tag_d;
            s_r1_q   <= s_r1_d;
            s_r2_q   <= s_r2_d;
        end
    end
`endif

    assign result = alu_calc(op_sel, a_sel, b_sel);

    // FIFO pointer/count next-state
    always_comb begin
        cnt_d = cnt_q;
        rd_d  = rd_q;
        wr_d  = wr_q;
        if (clr) begin
            cnt_d = '0;
            rd_d  = 1'b0;
            wr_d  = 1'b0;
        end else begin
            if (push) wr_d = ~wr_q;
            if (pop)  rd_d = ~rd_q;
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + 2'd1;
                2'b01:   cnt_d = cnt_q - 2'd1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // FIFO pointers, count and storage
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cnt_q <= '0;
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
            fifo_tag_q[0] <= '0;
            fifo_tag_q[1] <= '0;
            fifo_val_q[0] <= '0;
            fifo_val_q[1] <= '0;
        end else begin
            cnt_q <= cnt_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            if (push) begin
                fifo_tag_q[wr_q] <= tag_sel;
                fifo_val_q[wr_q] <= result;
            end
        end
    end

    // Head is gated so an empty FIFO broadcasts zeros.
    assign bus._cdb_ready  = (cnt_q != 2'd0);
    assign bus._cdb_rob_id = bus._cdb_ready ? fifo_tag_q[rd_q] : '0;
    assign bus._cdb_value  = bus._cdb_ready ? fifo_val_q[rd_q] : '0;

endmodule
